// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_A_AD,
      S_A_CS,
      S_A_STB,
      S_A_WREL,
      S_A_CSREL,
      S_A_ADREL,
      S_D_CS,
      S_D_STB,
      S_D_REL,
      S_D_CSREL,
      S_GAP
   } rtc_state_e;

   localparam logic [7:0] AD_IDLE  = 8'hFF;
   localparam logic       STB_IDLE = 1'b1;
   localparam logic       RTC_WR   = 1'b0;
   localparam logic       RTC_RD   = 1'b1;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rtc_bus_seq_if.sv
// RTC pin-side bus: multiplexed AD byte with its output enable and active-low strobes.
interface rtc_bus_seq_if;
   logic [7:0] ADout;
   logic       ad_oe;
   logic [7:0] ad_in;
   logic       ad;
   logic       cs;
   logic       wr;
   logic       rd;

   modport master (output ADout, ad_oe, ad, cs, wr, rd, input ad_in);
   modport slave  (input ADout, ad_oe, ad, cs, wr, rd, output ad_in);
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter providing the multi-cycle dwell of strobe and gap phases.
module rtc_phase_timer
   import rtc_bus_pkg::*;
#(
   parameter int unsigned MAX_CYC = 9
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           load,
   input  logic [width_of(MAX_CYC)-1:0]   load_val,
   output logic                           zero
);

   logic [width_of(MAX_CYC)-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_seq.sv
// Burst sequencer for the RTC multiplexed AD bus: address phase then data phase per item.
// Optional read transactions are compiled in with RTC_READBACK_EN.
module rtc_bus_seq
   import rtc_bus_pkg::*;
#(
   parameter  int unsigned N_MAX    = 4,
   parameter  int unsigned T_STROBE = 5,
   parameter  int unsigned T_GAP    = 9,
   localparam int unsigned IW       = width_of(N_MAX)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              enable,
   input  logic              rw,
   input  logic [IW:0]       count,
   output logic [IW-1:0]     idx,
   input  logic [7:0]        item_addr,
   input  logic [7:0]        item_data,
   rtc_bus_seq_if.master     bus,
   output logic              busy,
   output logic              done,
   output logic              abort,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   output logic [IW-1:0]     rd_idx
);

   localparam int unsigned   T_MAX  = (T_STROBE > T_GAP) ? T_STROBE : T_GAP;
   localparam int unsigned   TW     = width_of(T_MAX);
   localparam logic [TW-1:0] STB_LD = TW'(T_STROBE - 1);
   localparam logic [TW-1:0] GAP_LD = TW'((T_GAP > 0) ? T_GAP - 1 : 0);
   localparam logic [IW:0]   N_CAP  = (IW + 1)'(N_MAX);

   rtc_state_e    state;
   logic          start_q;
   logic          accept;
   logic [IW:0]   n_eff;
   logic [IW-1:0] n_last;
   logic [7:0]    addr_q;
   logic [7:0]    data_q;
   logic          is_rd;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_zero;
   logic          item_end;

   // Edge history runs through reset so a held start cannot retrigger afterwards.
   always_ff @(posedge clock) start_q <= start;

   assign accept   = (state == S_IDLE) && enable && start && !start_q;
   assign n_eff    = (count > N_CAP) ? N_CAP : count;
   assign item_end = (state == S_GAP && tmr_zero) || (state == S_D_CSREL && T_GAP == 0);

`ifdef RTC_READBACK_EN
   logic rw_q;
   always_ff @(posedge clock) begin
      if (reset)       rw_q <= RTC_WR;
      else if (accept) rw_q <= rw;
   end
   assign is_rd = (rw_q == RTC_RD);
`else
   logic unused_rw;
   assign unused_rw = rw;
   assign is_rd     = 1'b0;
`endif

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = STB_LD;
      case (state)
         S_A_CS, S_D_CS: tmr_load = 1'b1;
         S_D_CSREL: begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
         end
         default: ;
      endcase
   end

   rtc_phase_timer #(.MAX_CYC(T_MAX)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         n_last    <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         bus.ADout <= AD_IDLE;
         bus.ad_oe <= 1'b0;
         bus.ad    <= STB_IDLE;
         bus.cs    <= STB_IDLE;
         bus.wr    <= STB_IDLE;
         bus.rd    <= STB_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         abort     <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         rd_idx    <= '0;
      end else begin
         done     <= 1'b0;
         abort    <= 1'b0;
         rd_valid <= 1'b0;
         if (state != S_IDLE && !enable) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            abort     <= 1'b1;
            bus.ADout <= AD_IDLE;
            bus.ad_oe <= 1'b0;
            bus.ad    <= STB_IDLE;
            bus.cs    <= STB_IDLE;
            bus.wr    <= STB_IDLE;
            bus.rd    <= STB_IDLE;
         end else begin
            case (state)
               S_IDLE: if (accept) begin
                  idx <= '0;
                  if (n_eff == '0) begin
                     done <= 1'b1;
                  end else begin
                     n_last <= IW'(n_eff - 1'b1);
                     busy   <= 1'b1;
                     state  <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  addr_q <= item_addr;
                  data_q <= item_data;
                  bus.ad <= !STB_IDLE;
                  state  <= S_A_AD;
               end
               S_A_AD: begin
                  bus.cs <= !STB_IDLE;
                  state  <= S_A_CS;
               end
               S_A_CS: begin
                  bus.wr    <= !STB_IDLE;
                  bus.ADout <= addr_q;
                  bus.ad_oe <= 1'b1;
                  state     <= S_A_STB;
               end
               S_A_STB: if (tmr_zero) begin
                  bus.wr <= STB_IDLE;
                  state  <= S_A_WREL;
               end
               S_A_WREL: begin
                  bus.cs <= STB_IDLE;
                  state  <= S_A_CSREL;
               end
               S_A_CSREL: begin
                  bus.ad    <= STB_IDLE;
                  bus.ADout <= AD_IDLE;
                  bus.ad_oe <= 1'b0;
                  state     <= S_A_ADREL;
               end
               S_A_ADREL: begin
                  bus.cs <= !STB_IDLE;
                  state  <= S_D_CS;
               end
               S_D_CS: begin
                  if (is_rd) begin
                     bus.rd    <= !STB_IDLE;
                     bus.ad_oe <= 1'b0;
                  end else begin
                     bus.wr    <= !STB_IDLE;
                     bus.ADout <= data_q;
                     bus.ad_oe <= 1'b1;
                  end
                  state <= S_D_STB;
               end
               // Leaving the last strobe cycle samples ad_in, so capture and valid coincide.
               S_D_STB: if (tmr_zero) begin
                  bus.wr <= STB_IDLE;
                  bus.rd <= STB_IDLE;
                  if (is_rd) begin
                     rd_valid <= 1'b1;
                     rd_data  <= bus.ad_in;
                     rd_idx   <= idx;
                  end
                  state <= S_D_REL;
               end
               S_D_REL: begin
                  bus.cs    <= STB_IDLE;
                  bus.ADout <= AD_IDLE;
                  bus.ad_oe <= 1'b0;
                  state     <= S_D_CSREL;
               end
               S_D_CSREL, S_GAP: begin
                  if (!item_end) begin
                     state <= S_GAP;
                  end else if (idx == n_last) begin
                     idx   <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_LOAD;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Directed self-checking bench for rtc_bus_seq (default and fast-timing instances).
// Read-path vectors are exercised when RTC_READBACK_EN is defined.
module tb_rtc_bus_seq;

   localparam logic [12:0] PINS_IDLE = {4'b1111, 1'b0, 8'hFF};

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset, start0, start1, enable, rw;
   logic [2:0] count;
   logic [1:0] idx0, idx1, rdi0, rdi1;
   logic [7:0] addr0, addr1, data0, data1, rdd0, rdd1;
   logic       busy0, done0, abort0, rdv0;
   logic       busy1, done1, abort1, rdv1;

   logic [7:0] tbl_addr [0:3];
   logic [7:0] tbl_data [0:3];
   logic [7:0] rd_tbl   [0:3];

   int n_checks = 0;
   int n_pass   = 0;

   rtc_bus_seq_if b0 ();
   rtc_bus_seq_if b1 ();

   rtc_bus_seq dut (
      .clock (clock), .reset (reset), .start (start0), .enable (enable), .rw (rw),
      .count (count), .idx (idx0), .item_addr (addr0), .item_data (data0), .bus (b0),
      .busy (busy0), .done (done0), .abort (abort0), .rd_valid (rdv0),
      .rd_data (rdd0), .rd_idx (rdi0)
   );

   rtc_bus_seq #(.N_MAX(4), .T_STROBE(1), .T_GAP(0)) dut_f (
      .clock (clock), .reset (reset), .start (start1), .enable (enable), .rw (rw),
      .count (count), .idx (idx1), .item_addr (addr1), .item_data (data1), .bus (b1),
      .busy (busy1), .done (done1), .abort (abort1), .rd_valid (rdv1),
      .rd_data (rdd1), .rd_idx (rdi1)
   );

   always_comb begin
      addr0 = tbl_addr[idx0];
      data0 = tbl_data[idx0];
      addr1 = tbl_addr[idx1];
      data1 = tbl_data[idx1];
   end
   assign b0.ad_in = rd_tbl[idx0];
   assign b1.ad_in = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [18:0] get_obs(input int unsigned s);
      if (s == 1)
         return {b1.ad, b1.cs, b1.wr, b1.rd, b1.ad_oe, b1.ADout, busy1, done1, abort1, rdv1, idx1};
      return {b0.ad, b0.cs, b0.wr, b0.rd, b0.ad_oe, b0.ADout, busy0, done0, abort0, rdv0, idx0};
   endfunction

   // Expected pins for cycle k of an item (k=0 is LOAD) with strobe length t.
   function automatic logic [12:0] exp_pins(input int unsigned k, input int unsigned t,
                                             input logic rdop, input logic [7:0] a,
                                             input logic [7:0] d);
      logic ad_n, cs_n, wr_n, rd_n, oe;
      logic [7:0] v;
      ad_n = !(k >= 1 && k <= 4 + t);
      cs_n = !((k >= 2 && k <= 3 + t) || (k >= 6 + t && k <= 7 + 2 * t));
      wr_n = !((k >= 3 && k <= 2 + t) || (!rdop && k >= 7 + t && k <= 6 + 2 * t));
      rd_n = !(rdop && k >= 7 + t && k <= 6 + 2 * t);
      oe   = 1'b0;
      v    = 8'hFF;
      if (k >= 3 && k <= 4 + t) begin
         oe = 1'b1;
         v  = a;
      end else if (!rdop && k >= 7 + t && k <= 7 + 2 * t) begin
         oe = 1'b1;
         v  = d;
      end
      return {ad_n, cs_n, wr_n, rd_n, oe, v};
   endfunction

   task automatic set_start(input int unsigned s, input logic v);
      if (s == 1) start1 = v;
      else        start0 = v;
   endtask

   task automatic run_burst(input int unsigned s, input int unsigned cnt, input int unsigned nexp,
                            input logic rw_i, input int abort_at);
      int unsigned t, l;
      logic rdop;
      t = (s == 1) ? 1 : 5;
      l = (s == 1) ? 11 : 28;
`ifdef RTC_READBACK_EN
      rdop = rw_i;
`else
      rdop = 1'b0;
`endif
      count = 3'(cnt);
      rw    = rw_i;
      set_start(s, 1'b1);
      @(negedge clock);
      for (int c = 0; c < int'(nexp * l); c++) begin
         int unsigned item, k;
         logic rv;
         item = c / l;
         k    = c % l;
         rv   = rdop && (k == 7 + 2 * t);
         check($sformatf("s%0d_c%0d", s, c), 32'(get_obs(s)),
               32'({exp_pins(k, t, rdop, tbl_addr[item[1:0]], tbl_data[item[1:0]]),
                    1'b1, 1'b0, 1'b0, rv, item[1:0]}));
`ifdef RTC_READBACK_EN
         if (rv) begin
            check($sformatf("rd_data_%0d", item), 32'(rdd0), 32'(rd_tbl[item[1:0]]));
            check($sformatf("rd_idx_%0d", item), 32'(rdi0), 32'(item[1:0]));
         end
`endif
         if (c == 1)  set_start(s, 1'b0);
         if (c == 20) set_start(s, 1'b1);
         if (c == 22) set_start(s, 1'b0);
         if (abort_at >= 0 && c == abort_at) begin
            enable = 1'b0;
            @(negedge clock);
            check("abort", 32'(get_obs(s)), 32'({PINS_IDLE, 4'b0010, 2'b00}));
            enable = 1'b1;
            @(negedge clock);
            check("post_abort", 32'(get_obs(s)), 32'({PINS_IDLE, 4'b0000, 2'b00}));
            return;
         end
         if (c == int'(nexp * l) - 1) set_start(s, 1'b1);
         @(negedge clock);
      end
      check($sformatf("done_s%0d", s), 32'(get_obs(s)), 32'({PINS_IDLE, 4'b0100, 2'b00}));
      @(negedge clock);
      check($sformatf("after_done_s%0d", s), 32'(get_obs(s)), 32'({PINS_IDLE, 4'b0000, 2'b00}));
      set_start(s, 1'b0);
      @(negedge clock);
   endtask

   initial begin
      tbl_addr = '{8'h43, 8'h42, 8'h41, 8'hF2};
      tbl_data = '{8'h00, 8'h00, 8'h00, 8'h00};
      rd_tbl   = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
      reset  = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      enable = 1'b1;
      rw     = 1'b0;
      count  = 3'd0;
      repeat (3) @(negedge clock);
      check("rst_s0", 32'(get_obs(0)), 32'({PINS_IDLE, 6'b0}));
      check("rst_s1", 32'(get_obs(1)), 32'({PINS_IDLE, 6'b0}));
      check("rst_rd0", 32'({rdd0, rdi0}), 32'(0));
      check("rst_rd1", 32'({rdd1, rdi1}), 32'(0));
      reset = 1'b0;
      @(negedge clock);

      // Clear-sequence style write burst, 112 cycles then done.
      run_burst(0, 4, 4, 1'b0, -1);

      tbl_data = '{8'h5C, 8'h6D, 8'h7E, 8'h8F};
      run_burst(0, 4, 4, 1'b0, 40);
      run_burst(0, 4, 4, 1'b0, -1);

      run_burst(0, 0, 0, 1'b0, -1);
      run_burst(1, 7, 4, 1'b0, -1);

      // Start edge while disabled is dropped, not queued.
      enable = 1'b0;
      count  = 3'd2;
      start0 = 1'b1;
      @(negedge clock);
      check("dis_edge", 32'(get_obs(0)), 32'({PINS_IDLE, 6'b0}));
      enable = 1'b1;
      @(negedge clock);
      check("dis_edge_late", 32'(get_obs(0)), 32'({PINS_IDLE, 6'b0}));
      start0 = 1'b0;
      @(negedge clock);

      run_burst(0, 2, 2, 1'b1, -1);
`ifndef RTC_READBACK_EN
      check("rd_held", 32'({rdd0, rdi0}), 32'(0));
`endif

      // Reset in the middle of the address strobe.
      rw     = 1'b0;
      count  = 3'd4;
      start0 = 1'b1;
      repeat (5) @(negedge clock);
      check("pre_rst_wr", 32'(b0.wr), 32'(0));
      reset = 1'b1;
      @(negedge clock);
      check("rst_mid", 32'(get_obs(0)), 32'({PINS_IDLE, 6'b0}));
      reset  = 1'b0;
      start0 = 1'b0;
      @(negedge clock);
      check("rst_after", 32'(get_obs(0)), 32'({PINS_IDLE, 6'b0}));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
